keyboard_tx_queue: RTL and testbench

Buffers keystroke bytes from the keyboard/ASCII path and feeds them to the UART transmitter with proper busy handshaking, replacing the direct `scan_code_ready` → `TxD_start` connection, which loses keys while a byte is on the wire. Cursor-key codes expand into VT100 escape sequences (ESC `[` A–D) so the remote host sees standard terminal input. The block sits between `ScanCodeToAscii` and `async_transmitter` in the 100 MHz domain.

---
 rtl/keyboard_tx_queue.sv | 192 +++++++++++++++++++
 tb/tb_keyboard_tx_queue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_tx_queue.sv
// keyboard_tx_queue: buffers keystrokes for the UART transmitter and
// expands cursor keys into VT100 escape sequences (ESC [ A..D).
module keyboard_tx_queue #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   keyValid,
  input  logic [7:0]             keyCode,
  input  logic                   txBusy,
  output logic                   txStart,
  output logic [7:0]             txData,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_BRACKET,
    EX_LETTER
  } ex_state_t;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_WAIT_HI,
    DR_WAIT_LO
  } dr_state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          empty;
  logic [LW-1:0] free;
  logic [LW-1:0] level_n;

  ex_state_t     ex_q;
  ex_state_t     ex_n;
  logic [1:0]    arrow_q;
  logic [1:0]    arrow_n;
  logic          push;
  logic [7:0]    push_data;
  logic          ovf_set;
  logic          is_lit;
  logic          is_arw;

  dr_state_t     dr_q;
  dr_state_t     dr_n;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          pop;
  logic          start_n;

  assign empty  = (wptr == rptr);
  assign free   = LW'(DEPTH) - level;
  assign is_lit = ~keyCode[7];
  assign is_arw = keyCode[7] & ~|keyCode[6:2];

  always_comb begin
    level_n = level;
    if (push && !pop)
      level_n = level + LW'(1);
    else if (!push && pop)
      level_n = level - LW'(1);
  end

  // Expander: accept keys, reserve space, emit ESC [ letter for arrows.
  always_comb begin
    ex_n      = ex_q;
    arrow_n   = arrow_q;
    push      = 1'b0;
    push_data = 8'h00;
    ovf_set   = 1'b0;
    unique case (ex_q)
      EX_IDLE: begin
        if (keyValid) begin
          unique case (1'b1)
            is_lit: begin
              if (free >= LW'(1)) begin
                push      = 1'b1;
                push_data = keyCode;
              end else begin
                ovf_set = 1'b1;
              end
            end
            is_arw: begin
              if (free >= LW'(3)) begin
                push      = 1'b1;
                push_data = 8'h1B;
                arrow_n   = keyCode[1:0];
                ex_n      = EX_BRACKET;
              end else begin
                ovf_set = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      EX_BRACKET: begin
        push      = 1'b1;
        push_data = 8'h5B;
        ovf_set   = keyValid;
        ex_n      = EX_LETTER;
      end
      EX_LETTER: begin
        push      = 1'b1;
        push_data = 8'h41 + {6'b0, arrow_q};
        ovf_set   = keyValid;
        ex_n      = EX_IDLE;
      end
      default: ex_n = EX_IDLE;
    endcase
  end

  // Drain: start a byte, then wait for the busy pulse or a timeout.
  always_comb begin
    dr_n    = dr_q;
    cnt_n   = cnt_q;
    pop     = 1'b0;
    start_n = 1'b0;
    unique case (dr_q)
      DR_IDLE: begin
        if (!empty && !txBusy) begin
          start_n = 1'b1;
          pop     = 1'b1;
          cnt_n   = '0;
          dr_n    = DR_WAIT_HI;
        end
      end
      DR_WAIT_HI: begin
        if (txBusy)
          dr_n = DR_WAIT_LO;
        else if (cnt_q == CW'(BUSY_TIMEOUT - 1))
          dr_n = DR_IDLE;
        else
          cnt_n = cnt_q + CW'(1);
      end
      DR_WAIT_LO: begin
        if (!txBusy)
          dr_n = DR_IDLE;
      end
      default: dr_n = DR_IDLE;
    endcase
  end

  // Storage array, written at the tail pointer.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= push_data;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      ex_q     <= EX_IDLE;
      arrow_q  <= 2'b00;
      dr_q     <= DR_IDLE;
      cnt_q    <= '0;
      txStart  <= 1'b0;
      txData   <= 8'h00;
      overflow <= 1'b0;
      idle     <= 1'b1;
    end else begin
      if (push)
        wptr <= wptr + (AW+1)'(1);
      if (pop) begin
        rptr   <= rptr + (AW+1)'(1);
        txData <= mem[rptr[AW-1:0]];
      end
      level    <= level_n;
      ex_q     <= ex_n;
      arrow_q  <= arrow_n;
      dr_q     <= dr_n;
      cnt_q    <= cnt_n;
      txStart  <= start_n;
      overflow <= overflow | ovf_set;
      idle     <= (level_n == '0) &&
                  (ex_n == EX_IDLE) &&
                  (dr_n == DR_IDLE);
    end
  end

endmodule

// File: tb/tb_keyboard_tx_queue.sv
// tb_keyboard_tx_queue: directed scoreboard bench with a
// transmitter model for keyboard_tx_queue.
module tb_keyboard_tx_queue;

  localparam int DEPTH = 16;
  localparam int BT    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   keyValid;
  logic [7:0]             keyCode;
  logic                   txBusy = 1'b0;
  logic                   txStart;
  logic [7:0]             txData;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;
  logic                   idle;

  int cyc      = 0;
  int errors   = 0;
  int checks   = 0;
  int tx_mode  = 0;
  int busy_len = 20;
  int bcnt     = 0;
  logic prev_start = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_d[$];
  int         got_c[$];

  keyboard_tx_queue #(
    .DEPTH(DEPTH),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keyValid(keyValid),
    .keyCode(keyCode),
    .txBusy(txBusy),
    .txStart(txStart),
    .txData(txData),
    .overflow(overflow),
    .level(level),
    .idle(idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: busy one cycle after start for busy_len cycles
  // mode 1: never busy; mode 2: busy held high
  always @(posedge clk) begin
    if (tx_mode == 2) begin
      txBusy <= 1'b1;
    end else if (tx_mode == 1) begin
      txBusy <= 1'b0;
    end else if (txStart) begin
      bcnt   <= busy_len;
      txBusy <= 1'b1;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt   <= 0;
      txBusy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (txStart === 1'b1) begin
      got_d.push_back(txData);
      got_c.push_back(cyc);
      chk("start_while_busy", 32'(txBusy), 32'd0);
      chk("start_back_to_back", 32'(prev_start), 32'd0);
    end
    prev_start = txStart;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code, output int kc);
    tick();
    keyValid = 1'b1;
    keyCode  = code;
    kc       = cyc;
  endtask

  task automatic unkey();
    tick();
    keyValid = 1'b0;
    keyCode  = 8'h00;
  endtask

  task automatic do_reset();
    tick();
    rst      = 1'b1;
    keyValid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_tx(input string tag, output int scyc);
    int n;
    logic [7:0] e;
    n = 0;
    scyc = -1;
    while (got_d.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (got_d.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=none expected=txStart", tag);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_extra observed=%0h expected=none",
             tag, got_d[0]);
      void'(got_d.pop_front());
      scyc = got_c.pop_front();
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(got_d.pop_front()), 32'(e));
      scyc = got_c.pop_front();
    end
  endtask

  task automatic wait_idle(input string tag, output int ic);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ic = cyc;
    if (idle !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s_idle_timeout observed=%0b expected=1", tag, idle);
    end
  endtask

  initial begin
    int kc, kc2, s1, s2, s3, ic;
    rst      = 1'b1;
    keyValid = 1'b0;
    keyCode  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_txStart", 32'(txStart), 32'd0);
    chk("rst_txData", 32'(txData), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);

    // single literal
    tx_mode  = 0;
    busy_len = 20;
    key(8'h61, kc);
    exp_q.push_back(8'h61);
    @(negedge clk);
    chk("t1_level_same_cycle", 32'(level), 32'd0);
    unkey();
    @(negedge clk);
    chk("t1_level_next", 32'(level), 32'd1);
    chk("t1_idle_busy", 32'(idle), 32'd0);
    pop_tx("t1", s1);
    chk("t1_latency", 32'(s1), 32'(kc + 2));
    wait_idle("t1", ic);
    chk("t1_idle_cycle", 32'(ic), 32'(s1 + busy_len + 2));

    // arrow expansion while transmitter busy
    tx_mode = 2;
    tick();
    tick();
    key(8'h82, kc);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h43);
    unkey();
    @(negedge clk);
    chk("t2_level1", 32'(level), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_level2", 32'(level), 32'd2);
    tick();
    @(negedge clk);
    chk("t2_level3", 32'(level), 32'd3);
    chk("t2_no_overflow", 32'(overflow), 32'd0);
    busy_len = 5;
    tx_mode  = 0;
    pop_tx("t2_esc", s1);
    pop_tx("t2_bracket", s2);
    pop_tx("t2_letter", s3);
    chk("t2_gap1", 32'(s2), 32'(s1 + busy_len + 3));
    chk("t2_gap2", 32'(s3), 32'(s2 + busy_len + 3));
    wait_idle("t2", ic);

    // overflow on a full FIFO
    do_reset();
    tx_mode = 2;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      key(8'h30 + 8'(i), kc);
      exp_q.push_back(8'h30 + 8'(i));
    end
    unkey();
    @(negedge clk);
    chk("t3_full_level", 32'(level), 32'(DEPTH));
    chk("t3_full_no_ovf", 32'(overflow), 32'd0);
    key(8'h7E, kc);
    unkey();
    @(negedge clk);
    chk("t3_drop_level", 32'(level), 32'(DEPTH));
    chk("t3_drop_ovf", 32'(overflow), 32'd1);
    busy_len = 1;
    tx_mode  = 0;
    for (int i = 0; i < DEPTH; i++) pop_tx("t3_drain", s1);
    wait_idle("t3", ic);
    chk("t3_empty", 32'(level), 32'd0);

    // ignored codes and arrow needing three slots
    do_reset();
    tx_mode = 2;
    tick();
    tick();
    key(8'h90, kc);
    unkey();
    @(negedge clk);
    chk("t3_ignored_level", 32'(level), 32'd0);
    chk("t3_ignored_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 2; i++) key(8'h41 + 8'(i), kc);
    unkey();
    @(negedge clk);
    chk("t3_level14", 32'(level), 32'(DEPTH - 2));
    chk("t3_level14_ovf", 32'(overflow), 32'd0);
    key(8'h83, kc);
    unkey();
    tick();
    @(negedge clk);
    chk("t3_arrow_drop_level", 32'(level), 32'(DEPTH - 2));
    chk("t3_arrow_drop_ovf", 32'(overflow), 32'd1);
    key(8'h20, kc);
    unkey();
    @(negedge clk);
    chk("t3_level15", 32'(level), 32'(DEPTH - 1));
    do_reset();
    chk("t3_rst_ovf", 32'(overflow), 32'd0);
    chk("t3_rst_level", 32'(level), 32'd0);

    // key during expansion
    tick();
    key(8'h80, kc);
    key(8'h7A, kc2);
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h41);
    unkey();
    tick();
    @(negedge clk);
    chk("t4_level", 32'(level), 32'd3);
    chk("t4_ovf", 32'(overflow), 32'd1);
    busy_len = 2;
    tx_mode  = 0;
    pop_tx("t4_esc", s1);
    pop_tx("t4_bracket", s1);
    pop_tx("t4_letter", s1);
    wait_idle("t4", ic);
    repeat (10) tick();
    @(negedge clk);
    chk("t4_no_extra", 32'(got_d.size()), 32'd0);

    // busy timeout
    tx_mode = 1;
    tick();
    tick();
    key(8'h31, kc);
    key(8'h32, kc2);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    unkey();
    pop_tx("t5_first", s1);
    pop_tx("t5_second", s2);
    chk("t5_latency", 32'(s1), 32'(kc + 2));
    chk("t5_timeout_gap", 32'(s2), 32'(s1 + BT + 1));
    wait_idle("t5", ic);
    chk("t5_idle_cycle", 32'(ic), 32'(s2 + BT));

    // reset right after an arrow is accepted
    busy_len = 3;
    tx_mode  = 0;
    tick();
    tick();
    key(8'h81, kc);
    tick();
    keyValid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_txStart", 32'(txStart), 32'd0);
    repeat (20) tick();
    @(negedge clk);
    chk("t6_no_start", 32'(got_d.size()), 32'd0);
    chk("end_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
